wdt_ctrl: RTL and testbench

Watchdog controller that sequences a `counter_wdt` up-counter instance. It holds the timeout and warning thresholds, runs a four-state watchdog FSM, and accepts keyed kicks from a simple register-style configuration port. It raises a warning interrupt and then a fixed-length SoC reset request. It sits in the SoC peripheral domain between the peripheral bus bridge and the reset controller.

---
 rtl/wdt_pkg.sv | 22 ++
 rtl/counter_wdt.sv | 26 ++
 rtl/wdt_ctrl.sv | 122 ++++++++++++
 tb/tb_wdt_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared watchdog definitions: FSM state encoding, register map, CTRL bit positions and defaults.
package wdt_pkg;

    typedef enum logic [1:0] {
        WDT_DISABLED = 2'd0,
        WDT_RUNNING  = 2'd1,
        WDT_WARNED   = 2'd2,
        WDT_EXPIRED  = 2'd3
    } wdt_state_e;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd1;
    localparam logic [1:0] ADDR_WARN    = 2'd2;
    localparam logic [1:0] ADDR_KICK    = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_LOCK_BIT = 1;

    localparam logic [31:0] DEF_KICK_KEY         = 32'h5A5A_A5A5;
    localparam int          DEF_RST_PULSE_CYCLES = 16;

endpackage

// File: rtl/counter_wdt.sv
// Watchdog up-counter: clear loads init_value_i (clear beats enable), enable increments by one.
// One-cycle latency from clear/enable to count_o; no backpressure.
module counter_wdt
    import wdt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] init_value_i,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= init_value_i;
        end else if (enable_i) begin
            count_o <= count_o + 1'b1;
        end
    end

endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog controller: config registers, keyed kicks, warn IRQ then fixed-length reset request; state changes one edge after a threshold is seen.
// Define WDT_KICK_STRICT_EN to make a wrong-key kick while armed force expiry; otherwise wrong keys are ignored.
module wdt_ctrl
    import wdt_pkg::*;
#(
    parameter logic [31:0] KICK_KEY         = DEF_KICK_KEY,
    parameter int          RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    output logic        irq_warn_o,
    output logic        reset_req_o,
    output logic [31:0] count_o,
    output logic [1:0]  state_o
);

    localparam logic [1:0]  S_DISABLED = WDT_DISABLED;
    localparam logic [1:0]  S_RUNNING  = WDT_RUNNING;
    localparam logic [1:0]  S_WARNED   = WDT_WARNED;
    localparam logic [1:0]  S_EXPIRED  = WDT_EXPIRED;
    localparam logic [31:0] PULSE_LAST = 32'(RST_PULSE_CYCLES - 1);

    logic [1:0]  state, next_state;
    logic        ctrl_en, ctrl_lock;
    logic [31:0] timeout, warn;
    logic [31:0] pulse_cnt;
    logic        reset_req;
    logic        wr_ctrl, wr_timeout, wr_warn, wr_kick;
    logic        armed, kick_ok, kick_bad, pulse_done;
    logic        cnt_clear, cnt_enable;

    // Lock gates every config write except KICK.
    assign wr_ctrl    = cfg_we_i && (cfg_addr_i == ADDR_CTRL)    && !ctrl_lock;
    assign wr_timeout = cfg_we_i && (cfg_addr_i == ADDR_TIMEOUT) && !ctrl_lock;
    assign wr_warn    = cfg_we_i && (cfg_addr_i == ADDR_WARN)    && !ctrl_lock;
    assign wr_kick    = cfg_we_i && (cfg_addr_i == ADDR_KICK);

    assign armed      = (state == S_RUNNING) || (state == S_WARNED);
    assign kick_ok    = armed && wr_kick && (cfg_wdata_i == KICK_KEY);
`ifdef WDT_KICK_STRICT_EN
    assign kick_bad   = armed && wr_kick && (cfg_wdata_i != KICK_KEY);
`else
    assign kick_bad   = 1'b0;
`endif
    assign pulse_done = (pulse_cnt == PULSE_LAST);

    // Disable beats kick beats expiry beats warning.
    always_comb begin
        next_state = state;
        case (state)
            S_DISABLED: begin
                if (wr_ctrl && cfg_wdata_i[CTRL_EN_BIT]) next_state = S_RUNNING;
            end
            S_RUNNING, S_WARNED: begin
                if (wr_ctrl && !cfg_wdata_i[CTRL_EN_BIT])  next_state = S_DISABLED;
                else if (kick_ok)                          next_state = S_RUNNING;
                else if (kick_bad || (count_o >= timeout)) next_state = S_EXPIRED;
                else if ((state == S_RUNNING) && (count_o >= warn)) next_state = S_WARNED;
            end
            default: begin
                if (pulse_done) next_state = S_DISABLED;
            end
        endcase
    end

    assign cnt_enable = armed;
    assign cnt_clear  = kick_ok
                     || ((state == S_DISABLED) && (next_state == S_RUNNING))
                     || ((state != S_DISABLED) && (next_state == S_DISABLED));

    counter_wdt #(.WIDTH(32)) u_counter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .init_value_i (32'd0),
        .enable_i     (cnt_enable),
        .clear_i      (cnt_clear),
        .count_o      (count_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_DISABLED;
            ctrl_en   <= 1'b0;
            ctrl_lock <= 1'b0;
            timeout   <= 32'hFFFF_FFFF;
            warn      <= 32'hFFFF_FFFF;
            pulse_cnt <= 32'd0;
            reset_req <= 1'b0;
        end else begin
            state     <= next_state;
            reset_req <= (next_state == S_EXPIRED);
            pulse_cnt <= ((state == S_EXPIRED) && !pulse_done) ? pulse_cnt + 32'd1 : 32'd0;
            if (wr_ctrl) begin
                ctrl_en   <= cfg_wdata_i[CTRL_EN_BIT];
                ctrl_lock <= cfg_wdata_i[CTRL_LOCK_BIT];
            end
            // End of the reset pulse drops en but keeps lock.
            if ((state == S_EXPIRED) && pulse_done) ctrl_en <= 1'b0;
            if (wr_timeout) timeout <= cfg_wdata_i;
            if (wr_warn)    warn    <= cfg_wdata_i;
        end
    end

    always_comb begin
        cfg_rdata_o = 32'd0;
        case (cfg_addr_i)
            ADDR_CTRL:    cfg_rdata_o = {30'd0, ctrl_lock, ctrl_en};
            ADDR_TIMEOUT: cfg_rdata_o = timeout;
            ADDR_WARN:    cfg_rdata_o = warn;
            default:      cfg_rdata_o = 32'd0;
        endcase
    end

    assign state_o     = state;
    assign irq_warn_o  = (state == S_WARNED);
    assign reset_req_o = reset_req;

endmodule

// File: tb/tb_wdt_ctrl.sv
// Self-checking bench for wdt_ctrl: vector table, directed corner sequences, random traffic vs a reference model.
module tb_wdt_ctrl;

    localparam logic [31:0] KEY   = 32'h5A5A_A5A5;
    localparam int          PULSE = 16;
`ifdef WDT_KICK_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata, count;
    logic        irq, rreq;
    logic [1:0]  st;

    wdt_ctrl #(.KICK_KEY(KEY), .RST_PULSE_CYCLES(PULSE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(we), .cfg_addr_i(addr),
        .cfg_wdata_i(wdata), .cfg_rdata_o(rdata), .irq_warn_o(irq),
        .reset_req_o(rreq), .count_o(count), .state_o(st)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_en, m_lock, m_run, m_warn;
    int          m_left;           // remaining reset-pulse cycles, 0 when not expired
    logic [31:0] m_to, m_wn, m_cnt;

    function automatic logic [1:0] m_state();
        if (m_left > 0) return 2'd3;
        if (m_run)      return m_warn ? 2'd2 : 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_lock, m_en};
            2'd1:    return m_to;
            2'd2:    return m_wn;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_lock = 0; m_run = 0; m_warn = 0; m_left = 0;
        m_to = 32'hFFFF_FFFF; m_wn = 32'hFFFF_FFFF; m_cnt = 0;
    endtask

    task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
        bit          cfg_ok = w && !m_lock;
        bit          wc     = cfg_ok && (a == 2'd0);
        bit          kick   = w && (a == 2'd3);
        bit          ended  = 0;
        logic [31:0] c      = m_cnt;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin ended = 1; m_cnt = 0; end
        end else if (m_run) begin
            if (wc && !d[0]) begin
                m_run = 0; m_warn = 0; m_cnt = 0;
            end else if (kick && d == KEY) begin
                m_warn = 0; m_cnt = 0;
            end else if ((STRICT && kick && d != KEY) || c >= m_to) begin
                m_run = 0; m_warn = 0; m_left = PULSE; m_cnt = c + 1;
            end else begin
                if (c >= m_wn) m_warn = 1;
                m_cnt = c + 1;
            end
        end else if (wc && d[0]) begin
            m_run = 1; m_warn = 0; m_cnt = 0;
        end
        if (wc) begin m_en = d[0]; m_lock = d[1]; end
        if (cfg_ok && a == 2'd1) m_to = d;
        if (cfg_ok && a == 2'd2) m_wn = d;
        if (ended) m_en = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        idle();
        we = 1'b0; wdata = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        idle();
    endtask

    task automatic wait_cnt(input logic [31:0] n, input string name);
        int k = 0;
        while (count !== n && k < 200) begin idle(); k++; end
        chk(name, count, n);
    endtask

    task automatic wait_rreq(input string name);
        int k = 0;
        while (rreq !== 1'b1 && k < 200) begin idle(); k++; end
        chk(name, {31'd0, rreq}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] cnt;
        logic [1:0]  st;
        logic        irq;
        logic        rq;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [1:0] a, input logic [31:0] d,
                                input logic [31:0] c, input logic [1:0] s, input logic i, input logic r);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.cnt = c; v.st = s; v.irq = i; v.rq = r;
        return v;
    endfunction

    vec_t vecs[31];

    initial begin
        bit saw;

        // Basic timeout: TIMEOUT=10, WARN=6, enable; one row per cycle.
        vecs[0] = mk(1'b1, 2'd1, 32'd10, 32'd0, 2'd0, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 2'd2, 32'd6,  32'd0, 2'd0, 1'b0, 1'b0);
        vecs[2] = mk(1'b1, 2'd0, 32'd1,  32'd0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k <= 6; k++)  vecs[3 + k]  = mk(1'b0, 2'd0, 32'd0, 32'(k), 2'd1, 1'b0, 1'b0);
        for (int k = 7; k <= 10; k++) vecs[3 + k]  = mk(1'b0, 2'd0, 32'd0, 32'(k), 2'd2, 1'b1, 1'b0);
        for (int p = 0; p < 16; p++)  vecs[14 + p] = mk(1'b0, 2'd0, 32'd0, 32'd11, 2'd3, 1'b0, 1'b1);
        vecs[30] = mk(1'b0, 2'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0);

        // Reset state
        do_reset();
        chk("rst_state", {30'd0, st}, 32'd0);
        chk("rst_count", count, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rreq", {31'd0, rreq}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); #1;
            chk("rst_rdata", rdata, (a == 1 || a == 2) ? 32'hFFFF_FFFF : 32'd0);
        end

        // Vector table
        do_reset();
        for (int i = 0; i < 31; i++) begin
            we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
            @(negedge clk);
            chk("tbl_count", count, vecs[i].cnt);
            chk("tbl_state", {30'd0, st}, {30'd0, vecs[i].st});
            chk("tbl_irq", {31'd0, irq}, {31'd0, vecs[i].irq});
            chk("tbl_rreq", {31'd0, rreq}, {31'd0, vecs[i].rq});
            @(posedge clk); #1;
        end
        we = 1'b0;

        // Kick at count 8
        do_reset();
        wr(2'd1, 32'd10); wr(2'd2, 32'd6); wr(2'd0, 32'd1);
        wait_cnt(32'd8, "kick_wait8");
        chk("kick_irq_before", {31'd0, irq}, 32'd1);
        wr(2'd3, KEY);
        chk("kick_count", count, 32'd0);
        chk("kick_irq_after", {31'd0, irq}, 32'd0);
        saw = 0;
        repeat (10) begin idle(); if (rreq) saw = 1; end
        chk("kick_no_reset", {31'd0, saw}, 32'd0);

        // Wrong key at count 3
        do_reset();
        wr(2'd1, 32'd10); wr(2'd2, 32'd6); wr(2'd0, 32'd1);
        wait_cnt(32'd3, "wkey_wait3");
        wr(2'd3, 32'h0000_1234);
        chk("wkey_rreq", {31'd0, rreq}, {31'd0, STRICT});
        chk("wkey_state", {30'd0, st}, STRICT ? 32'd3 : 32'd1);

        // Lock
        do_reset();
        wr(2'd1, 32'd10); wr(2'd0, 32'd3);
        wr(2'd0, 32'd0); wr(2'd1, 32'd100);
        chk("lock_state", {30'd0, st}, 32'd1);
        addr = 2'd1; #1;
        chk("lock_timeout", rdata, 32'd10);
        wait_rreq("lock_expire");
        chk("lock_exp_count", count, 32'd11);
        repeat (16) idle();
        chk("lock_end_state", {30'd0, st}, 32'd0);
        addr = 2'd0; #1;
        chk("lock_ctrl_kept", rdata, 32'd2);

        // Boundary: WARN above TIMEOUT skips warning
        do_reset();
        wr(2'd2, 32'd20); wr(2'd1, 32'd5); wr(2'd0, 32'd1);
        saw = 0;
        for (int k = 0; k < 100 && !rreq; k++) begin idle(); if (irq) saw = 1; end
        chk("bnd_no_warn", {31'd0, saw}, 32'd0);
        chk("bnd_rreq", {31'd0, rreq}, 32'd1);
        chk("bnd_count", count, 32'd6);

        // Boundary: lowering TIMEOUT below count expires next cycle
        do_reset();
        wr(2'd1, 32'd100); wr(2'd0, 32'd1);
        wait_cnt(32'd4, "lower_wait4");
        wr(2'd1, 32'd2);
        chk("lower_state_now", {30'd0, st}, 32'd1);
        idle();
        chk("lower_rreq", {31'd0, rreq}, 32'd1);

        // Async reset during the 5th reset_req cycle
        do_reset();
        wr(2'd1, 32'd10); wr(2'd0, 32'd1);
        wait_rreq("arst_expire");
        repeat (4) idle();
        addr = 2'd1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rreq", {31'd0, rreq}, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        chk("arst_count", count, 32'd0);
        chk("arst_state", {30'd0, st}, 32'd0);
        chk("arst_timeout", rdata, 32'hFFFF_FFFF);
        @(negedge clk) rst_n = 1'b1;
        idle();

        // Random traffic against the model
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int cyc = 0; cyc < 400; cyc++) begin
                we   = ($urandom_range(0, 3) == 0);
                addr = 2'($urandom_range(0, 3));
                case (addr)
                    2'd0:    wdata = ($urandom_range(0, 39) == 0) ? 32'd3 : 32'($urandom_range(0, 1));
                    2'd3:    wdata = ($urandom_range(0, 1) == 0) ? KEY : $urandom;
                    default: wdata = 32'($urandom_range(0, 40));
                endcase
                @(negedge clk);
                chk("rnd_state", {30'd0, st}, {30'd0, m_state()});
                chk("rnd_count", count, m_cnt);
                chk("rnd_irq", {31'd0, irq}, {31'd0, m_state() == 2'd2});
                chk("rnd_rreq", {31'd0, rreq}, {31'd0, m_state() == 2'd3});
                chk("rnd_rdata", rdata, m_rdata(addr));
                @(posedge clk);
                model_edge(we, addr, wdata);
                #1;
            end
        end
        we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
